// File: rtl/pc_unit_if.sv
// pc_unit_if: control inputs and PC/RAS status outputs of the program-counter unit.
interface pc_unit_if #(parameter int WIDTH = 32);
  logic stall;
  logic branch_taken;
  logic jump;
  logic call;
  logic ret;
  logic [WIDTH-1:0] branch_offset;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_inc;
  logic ras_empty;
  logic ras_full;
  logic ras_err;
  logic misaligned;
  modport master (
    output stall, branch_taken, jump, call, ret, branch_offset, jump_target,
    input  pc, pc_plus_inc, ras_empty, ras_full, ras_err, misaligned
  );
  modport slave (
    input  stall, branch_taken, jump, call, ret, branch_offset, jump_target,
    output pc, pc_plus_inc, ras_empty, ras_full, ras_err, misaligned
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with stall/branch/jump/call/return and a circular return-address stack.
// Define PC_ALIGN_CHECK_EN to force next PC onto INC alignment and flag MISALIGNED.
module pc_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int INC = 4,
  parameter int RAS_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  pc_unit_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] MASK = WIDTH'(INC - 1);
`endif
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc, sel, top;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0] tp_q, tp_d, tp_nxt, tp_prv, widx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, mis_q, mis_d;
  logic empty, full, go, push, pop, swap, we;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == CW'(RAS_DEPTH);
    go = !bus.stall;
    pc_inc = pc_q + WIDTH'(INC);
    top = ras_q[tp_q];
    tp_nxt = (tp_q == PW'(RAS_DEPTH - 1)) ? '0 : tp_q + PW'(1);
    tp_prv = (tp_q == '0) ? PW'(RAS_DEPTH - 1) : tp_q - PW'(1);
    sel = bus.ret ? (empty ? pc_inc : top) :
          (bus.call || bus.jump) ? bus.jump_target :
          bus.branch_taken ? pc_inc + bus.branch_offset : pc_inc;
    push = go && bus.call && !bus.ret;
    pop = go && bus.ret && !bus.call && !empty;
    swap = go && bus.call && bus.ret;
    we = push || swap;
    // a push onto a full stack lands on the oldest slot, giving circular overwrite
    widx = push ? tp_nxt : tp_q;
    tp_d = push ? tp_nxt : pop ? tp_prv : tp_q;
    cnt_d = push ? (full ? cnt_q : cnt_q + CW'(1)) :
            pop ? cnt_q - CW'(1) :
            (swap && empty) ? CW'(1) : cnt_q;
    err_d = err_q || (go && bus.ret && empty);
`ifdef PC_ALIGN_CHECK_EN
    pc_d = go ? (sel & ~MASK) : pc_q;
    mis_d = mis_q || (go && |(sel & MASK));
`else
    pc_d = go ? sel : pc_q;
    mis_d = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
      tp_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      tp_q <= tp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      mis_q <= mis_d;
    end
  end
  // entries are only read while counted valid, so storage needs no reset
  always_ff @(posedge clk) begin
    if (we) ras_q[widx] <= pc_inc;
  end
  assign bus.pc = pc_q;
  assign bus.pc_plus_inc = pc_inc;
  assign bus.ras_empty = empty;
  assign bus.ras_full = full;
  assign bus.ras_err = err_q;
  assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed plan plus randomized traffic against a queue-based PC/RAS model.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic m_err, m_mis;

  pc_unit_if #(.WIDTH(32)) bus ();
  pc_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 32'h0;
    m_q.delete();
    m_err = 1'b0;
    m_mis = 1'b0;
  endtask

  task automatic model(input logic s, input logic br, input logic [31:0] off,
                       input logic j, input logic c, input logic r, input logic [31:0] t);
    logic [31:0] inc, nxt;
    if (s) return;
    inc = m_pc + 32'd4;
    if (r) begin
      if (m_q.size() == 0) begin
        nxt = inc;
        m_err = 1'b1;
        if (c) m_q.push_back(inc);
      end else begin
        nxt = m_q[$];
        if (c) m_q[$] = inc;
        else void'(m_q.pop_back());
      end
    end else if (c) begin
      nxt = t;
      m_q.push_back(inc);
      if (m_q.size() > 4) void'(m_q.pop_front());
    end else if (j) nxt = t;
    else if (br) nxt = inc + off;
    else nxt = inc;
`ifdef PC_ALIGN_CHECK_EN
    if (nxt % 4 != 0) m_mis = 1'b1;
    nxt = nxt - (nxt % 4);
`endif
    m_pc = nxt;
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("pc", bus.pc, m_pc);
      check("pc_plus_inc", bus.pc_plus_inc, m_pc + 32'd4);
      check("ras_empty", 32'(bus.ras_empty), 32'(m_q.size() == 0));
      check("ras_full", 32'(bus.ras_full), 32'(m_q.size() == 4));
      check("ras_err", 32'(bus.ras_err), 32'(m_err));
      check("misaligned", 32'(bus.misaligned), 32'(m_mis));
    end
  end

  task automatic cyc(input logic s, input logic br, input logic [31:0] off,
                     input logic j, input logic c, input logic r, input logic [31:0] t);
    bus.stall = s;
    bus.branch_taken = br;
    bus.branch_offset = off;
    bus.jump = j;
    bus.call = c;
    bus.ret = r;
    bus.jump_target = t;
    @(posedge clk);
    if (!rst) model(s, br, off, j, c, r, t);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jmp(input logic [31:0] t);
    cyc(0, 0, 0, 1, 0, 0, t);
  endtask

  task automatic call(input logic [31:0] t);
    cyc(0, 0, 0, 0, 1, 0, t);
  endtask

  task automatic ret();
    cyc(0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    logic [31:0] off, tgt;
    cyc(0, 0, 0, 0, 0, 0, 0);
    m_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    run = 1'b1;
    check("reset_pc", bus.pc, 32'h0);
    check("reset_empty", 32'(bus.ras_empty), 32'd1);
    check("reset_full", 32'(bus.ras_full), 32'd0);
    idle(); check("seq_4", bus.pc, 32'h4);
    idle(); check("seq_8", bus.pc, 32'h8);
    idle(); check("seq_c", bus.pc, 32'hc);
    idle(); check("seq_10", bus.pc, 32'h10);
    cyc(0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0); check("branch_back", bus.pc, 32'hc);
    cyc(1, 1, 32'h40, 1, 1, 1, 32'h999); check("stall_hold", bus.pc, 32'hc);
    jmp(32'h20); check("jump_20", bus.pc, 32'h20);
    call(32'h100); check("call_pc", bus.pc, 32'h100);
    check("call_link", bus.pc_plus_inc, 32'h104);
    idle(); idle();
    ret(); check("ret_pc", bus.pc, 32'h24);
    check("ret_empty", 32'(bus.ras_empty), 32'd1);
    jmp(32'h0);
    call(32'h100); call(32'h200); call(32'h300); call(32'h400); call(32'h500);
    check("ovf_full", 32'(bus.ras_full), 32'd1);
    check("ovf_noerr", 32'(bus.ras_err), 32'd0);
    ret(); check("ret1", bus.pc, 32'h404);
    ret(); check("ret2", bus.pc, 32'h304);
    ret(); check("ret3", bus.pc, 32'h204);
    ret(); check("ret4", bus.pc, 32'h104);
    ret(); check("ret_under", bus.pc, 32'h108);
    check("ret_err", 32'(bus.ras_err), 32'd1);
    jmp(32'h4c);
    call(32'hFFFF_FFFC); check("call_top", bus.pc, 32'hFFFF_FFFC);
    idle(); check("wrap", bus.pc, 32'h0);
    cyc(0, 0, 0, 0, 1, 1, 32'h777); check("swap_pc", bus.pc, 32'h50);
    check("swap_count", 32'(bus.ras_empty), 32'd0);
    ret(); check("swap_top", bus.pc, 32'h4);
    check("swap_empty", 32'(bus.ras_empty), 32'd1);
    call(32'h200); call(32'h300);
    #2 rst = 1'b1;
    m_reset();
    #1;
    check("async_pc", bus.pc, 32'h0);
    check("async_empty", 32'(bus.ras_empty), 32'd1);
    check("async_err", 32'(bus.ras_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    jmp(32'h103);
`ifdef PC_ALIGN_CHECK_EN
    check("align_pc", bus.pc, 32'h100);
    check("align_flag", 32'(bus.misaligned), 32'd1);
`else
    check("align_pc", bus.pc, 32'h103);
    check("align_flag", 32'(bus.misaligned), 32'd0);
`endif
    jmp(32'h1000);
    for (int i = 0; i < 3000; i++) begin
      off = $urandom_range(0, 3) == 0 ? $urandom & ~32'h3 : ($urandom_range(0, 512) - 256) & ~32'h3;
      tgt = $urandom & ~32'h3;
      if ($urandom_range(0, 15) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, off,
          $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, tgt);
    end
    @(negedge clk);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit, successor to the basic +4 program counter.
- Adds stall, taken-branch (PC-relative), absolute jump, call/return, and a configurable-depth return-address stack (RAS).
- Sits at the head of the fetch path: PC drives the instruction memory address; control inputs come from the decode/branch logic.

Parameters:
- WIDTH, 32, PC and address width in bits.
- RESET_VECTOR, 0, PC value loaded on reset.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of return-address stack entries (≥2).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- STALL  input  1  hold PC and RAS unchanged this cycle.
- BRANCH_TAKEN  input  1  take a PC-relative branch.
- BRANCH_OFFSET  input  WIDTH  signed byte offset, added to PC+INC.
- JUMP  input  1  absolute jump to JUMP_TARGET.
- CALL  input  1  jump to JUMP_TARGET and push PC+INC onto the RAS.
- RET  input  1  pop the RAS and jump to the popped address.
- JUMP_TARGET  input  WIDTH  absolute target for JUMP/CALL.
- PC  output  WIDTH  current fetch address (registered).
- PC_PLUS_INC  output  WIDTH  combinational PC+INC (link value).
- RAS_EMPTY  output  1  RAS holds 0 entries.
- RAS_FULL  output  1  RAS holds RAS_DEPTH entries.
- RAS_ERR  output  1  sticky; set on RET with an empty RAS.
- MISALIGNED  output  1  sticky alignment fault (see Optional Feature).

Behaviour:
- RESET asserted (asynchronous): PC=RESET_VECTOR, RAS count=0, RAS_EMPTY=1, RAS_FULL=0, RAS_ERR=0, MISALIGNED=0.
  - Reset asserted mid-operation discards any pending update immediately.
- Latency: one cycle. The next-PC selection is combinational; PC updates on the CLK rising edge.
- Priority per cycle: STALL > RET > CALL > JUMP > BRANCH_TAKEN > sequential.
  - STALL: PC, RAS, and sticky flags all hold; all other inputs are ignored.
  - RET, RAS non-empty: PC←top entry, count−1.
  - RET, RAS empty: PC←PC+INC, RAS_ERR←1, count stays 0.
  - CALL: PC←JUMP_TARGET; push PC+INC.
  - JUMP: PC←JUMP_TARGET; RAS untouched.
  - BRANCH_TAKEN: PC←PC+INC+BRANCH_OFFSET.
  - None asserted: PC←PC+INC.
- CALL and RET asserted together (tail-call swap):
  - PC←popped top (or PC+INC with RAS_ERR←1 if empty).
  - The top entry is then replaced by PC+INC; count is unchanged (becomes 1 if it was empty).
- RAS overflow: CALL when full is a circular overwrite of the oldest entry. Count saturates at RAS_DEPTH; RAS_FULL stays 1; no error flag.
- Arithmetic: all additions are modulo 2^WIDTH. Wrap past all-ones to 0 is legal and silent.
- RAS storage is a circular buffer with a top pointer of clog2(RAS_DEPTH) bits plus a count of clog2(RAS_DEPTH+1) bits.
- RAS_EMPTY and RAS_FULL are decoded from the registered count.
- RAS_ERR clears only on RESET.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- With the macro defined: if the selected next PC is not a multiple of INC (INC a power of two), the low log2(INC) bits are forced to 0 before load and MISALIGNED is set (sticky until RESET).
- Without the macro: next PC is loaded unmodified and MISALIGNED is tied to 0.

Test Plan:
- Reset then 3 idle cycles, defaults -> PC sequence 0,4,8,12; RAS_EMPTY=1.
- At PC=0x10, BRANCH_TAKEN with BRANCH_OFFSET=−8 (0xFFFFFFF8) -> PC=0x0C. Next cycle with STALL=1 -> PC holds at 0x0C.
- At PC=0x20, CALL with target 0x100 -> PC=0x100, RAS top=0x24. Two idle cycles then RET -> PC=0x24, RAS_EMPTY=1.
- RAS_DEPTH=4: five CALLs from PCs 0x0,0x100,0x200,0x300,0x400 (target=next PC each) -> RAS_FULL=1. Five RETs -> PCs 0x404,0x304,0x204,0x104, then 0x108 with RAS_ERR=1.
- At PC=0xFFFFFFFC, idle -> PC=0x0. CALL+RET together with top=0x50 at PC=0x0 -> PC=0x50, top=0x4, count unchanged.
- RESET asserted asynchronously between clock edges while RAS count=2 -> PC=RESET_VECTOR and count=0 before the next edge. With PC_ALIGN_CHECK_EN defined, JUMP to 0x103 -> PC=0x100, MISALIGNED=1.
